// File: rtl/skinny_io_pkg.sv
// Shared definitions for the SKINNY share loader front end.
// Holds the FSM state type, command bytes, LFSR constants and frame sizes.
package skinny_io_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSeed,
        StPayload,
        StGen,
        StStart,
        StWaitLo,
        StWaitHi,
        StTx
    } state_e;

    localparam logic [7:0]  CMD_SEED = 8'h01;
    localparam logic [7:0]  CMD_ENC  = 8'h02;

    localparam logic [31:0] LFSR_SEED_DEFAULT = 32'h0000_0001;

    // Feedback taps: new = l[31] ^ l[21] ^ l[1] ^ l[0]
    localparam int unsigned LFSR_TAP3 = 31;
    localparam int unsigned LFSR_TAP2 = 21;
    localparam int unsigned LFSR_TAP1 = 1;
    localparam int unsigned LFSR_TAP0 = 0;

    localparam int unsigned GEN_CYCLES    = 184;
    localparam int unsigned PAYLOAD_BYTES = 64;

endpackage

// File: rtl/skinny_lfsr8.sv
// 32-bit Fibonacci LFSR that advances 8 steps per enable and emits the 8 new bits,
// first-generated bit in the MSB. An all-zero load falls back to the default seed.
module skinny_lfsr8
    import skinny_io_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [31:0] i_seed,
    input  logic        i_en,
    output logic [7:0]  o_byte
);

    logic [31:0] r_state;
    logic [31:0] w_next;
    logic        w_bit;

    always_comb begin
        w_next = r_state;
        w_bit  = 1'b0;
        o_byte = '0;
        for (int i = 7; i >= 0; i--) begin
            w_bit     = w_next[LFSR_TAP3] ^ w_next[LFSR_TAP2] ^ w_next[LFSR_TAP1] ^ w_next[LFSR_TAP0];
            w_next    = {w_next[30:0], w_bit};
            o_byte[i] = w_bit;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= LFSR_SEED_DEFAULT;
        end else if (i_load) begin
            r_state <= (i_seed == '0) ? LFSR_SEED_DEFAULT : i_seed;
        end else if (i_en) begin
            r_state <= w_next;
        end
    end

endmodule

// File: rtl/skinny_share_loader.sv
// Byte-serial front end for the 2-share SKINNY core: seeds the PRNG, masks pt/key,
// generates core randomness, runs the core and streams the unmasked ciphertext out.
module skinny_share_loader
    import skinny_io_pkg::*;
#(
    parameter int unsigned RND_W  = 1216,
    parameter int unsigned MASK_W = 256
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_valid_i,
    output logic [7:0]       tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    output logic             start_o,
    input  logic             done_i,
    output logic [255:0]     input_o,
    output logic [255:0]     key_o,
    output logic [127:0]     tweak1_o,
    output logic [127:0]     tweak2_o,
    output logic [RND_W-1:0] random_o,
    input  logic [255:0]     cipher_i,
    output logic             busy_o,
    output logic             err_o
);

    localparam int unsigned GEN_W = RND_W + MASK_W;
    localparam int unsigned GEN_N = GEN_W / 8;
    localparam int unsigned GCW   = $clog2(GEN_N);

    state_e           r_state, w_state_next;
    logic [5:0]       r_cnt, w_cnt_next;
    logic [GCW-1:0]   r_gen_cnt, w_gen_cnt_next;
    logic             r_err;
    logic [23:0]      r_seed;
    logic [127:0]     r_pt, r_key, r_tw1, r_tw2, r_ct;
    logic [GEN_W-1:0] r_gen;
    logic [255:0]     r_input, r_key_sh;
    logic [RND_W-1:0] r_random;

    logic             w_err_set, w_tx_fire, w_gen_last, w_lfsr_load;
    logic [7:0]       w_lfsr_byte;
    logic [GEN_W-1:0] w_gen_next;
    logic [127:0]     w_mpt, w_mk;

    assign w_gen_last  = (r_gen_cnt == GCW'(GEN_N - 1));
    assign w_lfsr_load = (r_state == StSeed) && rx_valid_i && (r_cnt == 6'd3);
    assign w_gen_next  = {r_gen[GEN_W-9:0], w_lfsr_byte};
    assign w_mpt       = w_gen_next[GEN_W-1 -: 128];
    assign w_mk        = w_gen_next[GEN_W-129 -: 128];

    skinny_lfsr8 u_lfsr (
        .i_clk  (clk_i),
        .i_rst  (rst_i),
        .i_load (w_lfsr_load),
        .i_seed ({r_seed, rx_data_i}),
        .i_en   (r_state == StGen),
        .o_byte (w_lfsr_byte)
    );

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_gen_cnt_next = r_gen_cnt;
        start_o        = 1'b0;
        tx_valid_o     = 1'b0;
        busy_o         = 1'b1;
        w_tx_fire      = 1'b0;
        // Bytes are only consumed in IDLE, SEED and PAYLOAD; anywhere else they are errors.
        w_err_set      = rx_valid_i && !(r_state inside {StIdle, StSeed, StPayload});
        case (r_state)
            StIdle: begin
                busy_o = 1'b0;
                if (rx_valid_i) begin
                    if (rx_data_i == CMD_SEED)     w_state_next = StSeed;
                    else if (rx_data_i == CMD_ENC) w_state_next = StPayload;
                    else                           w_err_set    = 1'b1;
                end
            end
            StSeed: begin
                if (rx_valid_i) begin
                    w_cnt_next = (r_cnt == 6'd3) ? 6'd0 : r_cnt + 6'd1;
                    if (r_cnt == 6'd3) w_state_next = StIdle;
                end
            end
            StPayload: begin
                if (rx_valid_i) begin
                    w_cnt_next = r_cnt + 6'd1;
                    if (r_cnt == 6'(PAYLOAD_BYTES - 1)) w_state_next = StGen;
                end
            end
            StGen: begin
                w_gen_cnt_next = w_gen_last ? '0 : r_gen_cnt + GCW'(1);
                if (w_gen_last) w_state_next = StStart;
            end
            StStart: begin
                start_o      = 1'b1;
                w_state_next = StWaitLo;
            end
            StWaitLo: if (!done_i) w_state_next = StWaitHi;
            StWaitHi: if (done_i)  w_state_next = StTx;
            StTx: begin
                tx_valid_o = 1'b1;
                w_tx_fire  = tx_ready_i;
                if (w_tx_fire) begin
                    w_cnt_next = (r_cnt == 6'd15) ? 6'd0 : r_cnt + 6'd1;
                    if (r_cnt == 6'd15) w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_gen_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_gen_cnt <= w_gen_cnt_next;
            if (w_err_set) r_err <= 1'b1;
        end
    end

    // Datapath registers carry no reset; the control state alone discards partial frames.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (r_state == StSeed && rx_valid_i) r_seed <= {r_seed[15:0], rx_data_i};
            if (r_state == StPayload && rx_valid_i) begin
                case (r_cnt[5:4])
                    2'd0: r_pt  <= {r_pt[119:0], rx_data_i};
                    2'd1: r_key <= {r_key[119:0], rx_data_i};
                    2'd2: r_tw1 <= {r_tw1[119:0], rx_data_i};
                    2'd3: r_tw2 <= {r_tw2[119:0], rx_data_i};
                endcase
            end
            if (r_state == StGen) begin
                r_gen <= w_gen_next;
                if (w_gen_last) begin
                    r_input  <= {w_mpt, r_pt ^ w_mpt};
                    r_key_sh <= {w_mk, r_key ^ w_mk};
                    r_random <= w_gen_next[RND_W-1:0];
                end
            end
            if (r_state == StWaitHi && done_i) r_ct <= cipher_i[127:0] ^ cipher_i[255:128];
            else if (w_tx_fire)                r_ct <= {r_ct[119:0], 8'h00};
        end
    end

    assign tx_data_o = r_ct[127:120];
    assign input_o   = r_input;
    assign key_o     = r_key_sh;
    assign tweak1_o  = r_tw1;
    assign tweak2_o  = r_tw2;
    assign random_o  = r_random;
    assign err_o     = r_err;

endmodule

// File: tb/tb_skinny_share_loader.sv
// Directed/randomized bench for skinny_share_loader with a bitstream PRNG model,
// a toy core stub and a TX scoreboard.
module tb_skinny_share_loader;

    logic          clk = 1'b0;
    logic          rst_i, rx_valid_i, tx_ready_i, done_i;
    logic [7:0]    rx_data_i, tx_data_o;
    logic          tx_valid_o, start_o, busy_o, err_o;
    logic [255:0]  input_o, key_o, cipher_i;
    logic [127:0]  tweak1_o, tweak2_o;
    logic [1215:0] random_o;

    int            n_vec = 0, n_err = 0, cyc = 0, last_cyc = 0, n_start = 0;
    logic [31:0]   m_lfsr;
    bit            exp_err;
    bit            pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    skinny_share_loader dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .start_o    (start_o),
        .done_i     (done_i),
        .input_o    (input_o),
        .key_o      (key_o),
        .tweak1_o   (tweak1_o),
        .tweak2_o   (tweak2_o),
        .random_o   (random_o),
        .cipher_i   (cipher_i),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (start_o === 1'b1) n_start <= n_start + 1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        logic [255:0] r;
        r = rand256();
        return r[127:0];
    endfunction

    // Stand-in for the cipher: any fixed function of the unmasked inputs will do.
    function automatic logic [127:0] core_model(input logic [127:0] pt, key, tw1, tw2);
        return (pt ^ key) + (tw1 ^ {tw2[63:0], tw2[127:64]});
    endfunction

    // Produce the next 1472 PRNG bits as one stream and slice them into the mask fields.
    task automatic gen_model(output logic [127:0] mpt, mk, output logic [1215:0] rnd);
        logic nb;
        for (int i = 0; i < 1472; i++) begin
            nb     = m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0];
            m_lfsr = {m_lfsr[30:0], nb};
            if (i < 128)      mpt[127 - i]  = nb;
            else if (i < 256) mk[255 - i]   = nb;
            else              rnd[1471 - i] = nb;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        last_cyc   = cyc;
        step();
        rx_valid_i = 1'b0;
    endtask

    task automatic load_seed(input logic [31:0] s);
        send_byte(8'h01);
        for (int i = 0; i < 4; i++) send_byte(s[31 - 8*i -: 8]);
        m_lfsr = (s == 32'h0) ? 32'h1 : s;
        chk("seed_idle_busy", 256'(busy_o), 256'(0));
    endtask

    task automatic run_frame(input string nm, input logic [127:0] pt, key, tw1, tw2,
                             input bit inject, input bit rnd_ready);
        logic [127:0]  fld [4];
        logic [127:0]  mpt, mk, ct, cmask;
        logic [1215:0] rnd;
        logic [7:0]    txq [16];
        logic [7:0]    d, prev;
        int            s0, got, unstable;
        bit            found, tx_seen, v, stalled;
        fld = '{pt, key, tw1, tw2};
        s0  = n_start;
        gen_model(mpt, mk, rnd);
        ct  = core_model(pt, key, tw1, tw2);
        send_byte(8'h02);
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 16; i++) send_byte(fld[f][127 - 8*i -: 8]);
        found   = 1'b0;
        tx_seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (start_o === 1'b1) begin
                found = 1'b1;
                break;
            end
            if (tx_valid_o === 1'b1) tx_seen = 1'b1;
            rx_data_i  = 8'h55;
            rx_valid_i = inject && (k == 10);
            step();
        end
        rx_valid_i = 1'b0;
        if (inject) exp_err = 1'b1;
        chk({nm, "_start_seen"}, 256'(found), 256'(1));
        chk({nm, "_latency"}, 256'(cyc - last_cyc), 256'(185));
        chk({nm, "_input"}, input_o, {mpt, pt ^ mpt});
        chk({nm, "_key"}, key_o, {mk, key ^ mk});
        chk({nm, "_tweak1"}, 256'(tweak1_o), 256'(tw1));
        chk({nm, "_tweak2"}, 256'(tweak2_o), 256'(tw2));
        for (int c = 0; c < 19; c++)
            chk($sformatf("%s_random%0d", nm, c), 256'(random_o[c*64 +: 64]),
                256'(rnd[c*64 +: 64]));
        // Core stub: done high 3 cycles, low 40, then high with valid shares for one cycle.
        for (int j = 0; j < 3; j++) begin
            step();
            if (tx_valid_o === 1'b1) tx_seen = 1'b1;
        end
        done_i = 1'b0;
        for (int j = 0; j < 40; j++) begin
            cipher_i = rand256();
            step();
            if (tx_valid_o === 1'b1) tx_seen = 1'b1;
        end
        chk({nm, "_busy_wait"}, 256'(busy_o), 256'(1));
        chk({nm, "_no_tx_before_done"}, 256'(tx_seen), 256'(0));
        cmask    = rand128();
        done_i   = 1'b1;
        cipher_i = {cmask, ct ^ cmask};
        step();
        cipher_i = rand256();
        got      = 0;
        unstable = 0;
        stalled  = 1'b0;
        prev     = 8'h00;
        for (int k = 0; k < 200 && got < 16; k++) begin
            tx_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : pat[k % 4];
            v = tx_valid_o;
            d = tx_data_o;
            if (stalled && (!v || d !== prev)) unstable++;
            step();
            if (v && tx_ready_i) begin
                txq[got] = d;
                got++;
                stalled = 1'b0;
            end else begin
                stalled = v;
                prev    = d;
            end
        end
        tx_ready_i = 1'b0;
        chk({nm, "_tx_count"}, 256'(got), 256'(16));
        chk({nm, "_tx_stable"}, 256'(unstable), 256'(0));
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_tx%0d", nm, i), 256'(txq[i]), 256'(ct[127 - 8*i -: 8]));
        chk({nm, "_tx_valid_end"}, 256'(tx_valid_o), 256'(0));
        chk({nm, "_busy_end"}, 256'(busy_o), 256'(0));
        chk({nm, "_start_count"}, 256'(n_start - s0), 256'(1));
        chk({nm, "_err"}, 256'(err_o), 256'(exp_err));
    endtask

    initial begin
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        tx_ready_i = 1'b0;
        done_i     = 1'b1;
        cipher_i   = '0;
        rst_i      = 1'b1;
        repeat (3) step();
        rst_i   = 1'b0;
        m_lfsr  = 32'h1;
        exp_err = 1'b0;
        chk("rst_tx_valid", 256'(tx_valid_o), 256'(0));
        chk("rst_start", 256'(start_o), 256'(0));
        chk("rst_err", 256'(err_o), 256'(0));
        chk("rst_busy", 256'(busy_o), 256'(0));

        load_seed(32'h0000_0000);
        run_frame("zeroseed", rand128(), rand128(), rand128(), rand128(), 1'b0, 1'b0);

        load_seed(32'hDEAD_BEEF);
        run_frame("deadbeef", 128'h000102030405060708090a0b0c0d0e0f,
                  128'h101112131415161718191a1b1c1d1e1f, 128'h202122232425262728292a2b2c2d2e2f,
                  128'h303132333435363738393a3b3c3d3e3f, 1'b0, 1'b0);
        chk("pt_unmask", 256'(input_o[127:0] ^ input_o[255:128]),
            256'(128'h000102030405060708090a0b0c0d0e0f));

        send_byte(8'h7F);
        exp_err = 1'b1;
        chk("badcmd_err", 256'(err_o), 256'(1));
        chk("badcmd_busy", 256'(busy_o), 256'(0));
        run_frame("gen_rx", rand128(), rand128(), rand128(), rand128(), 1'b1, 1'b0);

        send_byte(8'h02);
        for (int i = 0; i < 30; i++) send_byte(8'($urandom()));
        rst_i = 1'b1;
        step();
        rst_i   = 1'b0;
        m_lfsr  = 32'h1;
        exp_err = 1'b0;
        chk("midrst_busy", 256'(busy_o), 256'(0));
        chk("midrst_tx_valid", 256'(tx_valid_o), 256'(0));
        chk("midrst_start", 256'(start_o), 256'(0));
        chk("midrst_err", 256'(err_o), 256'(0));
        run_frame("after_rst", rand128(), rand128(), rand128(), rand128(), 1'b0, 1'b0);
        run_frame("fresh", rand128(), rand128(), rand128(), rand128(), 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
